// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types for the handshaked data memory.
//   size_e  - access size encoding as seen on the size port
//   state_e - control FSM states
//   cnt_width() - wait-state counter width for a given latency
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_BAD  = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } state_e;

    // A zero latency still needs a 1-bit counter so the register exists.
    function automatic int unsigned cnt_width(input int unsigned lat);
        return (lat == 0) ? 1 : $clog2(lat + 1);
    endfunction

endpackage

// File: rtl/dmem_hs_if.sv
// dmem_hs_if: request/response bundle between the datapath memory stage
// (master) and dmem_hs (slave).
//   req/we/size/uns/adr/wd : request, driven by master
//   ready/ack/rd/err       : status and load result, driven by slave
interface dmem_hs_if;
    import dmem_pkg::*;

    logic        req;
    logic        we;
    size_e       size;
    logic        uns;
    logic [31:0] adr;
    logic [31:0] wd;
    logic        ready;
    logic        ack;
    logic [31:0] rd;
    logic        err;

    modport master (
        output req, we, size, uns, adr, wd,
        input  ready, ack, rd, err
    );

    modport slave (
        input  req, we, size, uns, adr, wd,
        output ready, ack, rd, err
    );

endinterface

// File: rtl/dmem_ram.sv
// dmem_ram: WORDS x 32 storage with per-byte write enable.
//   clk   - write clock
//   be    - byte write enables, bit k writes bits 8k+7:8k
//   addr  - word index
//   wdata - write data (already lane-steered)
//   rdata - combinational read of the addressed word
// Contents are deliberately not reset.
module dmem_ram #(
    parameter int unsigned WORDS = 64,
    parameter int unsigned AW    = 6
) (
    input  logic          clk,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [WORDS];

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/dmem_hs.sv
// dmem_hs: handshaked data memory with sub-word access, programmable wait
// states and error reporting for misaligned / out-of-range accesses.
//   clk   - clock
//   reset - asynchronous active-high; clears control state and outputs only
//   bus   - dmem_hs_if slave port (req/we/size/uns/adr/wd in,
//           ready/ack/rd/err out)
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | ready=1, waiting for req; request fields latched on accept
// WAIT  | counting down wait states; access performed when cnt==0
// RESP  | ack=1 for one cycle; rd/err hold the result
module dmem_hs
    import dmem_pkg::*;
#(
    parameter int unsigned WORDS   = 64,
    parameter int unsigned LATENCY = 2
) (
    input  logic      clk,
    input  logic      reset,
    dmem_hs_if.slave  bus
);

    localparam int unsigned CW = cnt_width(LATENCY);
    localparam int unsigned AW = (WORDS <= 1) ? 1 : $clog2(WORDS);
    localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY);

    state_e        state, state_n;
    logic [CW-1:0] cnt;
    logic          do_access;

    logic          we_q;
    logic          uns_q;
    size_e         size_q;
    logic [31:0]   adr_q;
    logic [31:0]   wd_q;
    logic [31:0]   rd_q;
    logic          err_q;

    logic          bad;
    logic [3:0]    be;
    logic [3:0]    ram_be;
    logic [31:0]   wlane;
    logic [31:0]   rword;
    logic [31:0]   shifted;
    logic [31:0]   lval;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        bus.ready = 1'b0;
        bus.ack   = 1'b0;
        do_access = 1'b0;
        case (state)
            IDLE: begin
                bus.ready = 1'b1;
                if (bus.req) state_n = WAIT;
            end
            WAIT: begin
                if (cnt == '0) begin
                    do_access = 1'b1;
                    state_n   = RESP;
                end
            end
            RESP: begin
                bus.ack = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // ---------------- request latch, counter, result ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt    <= '0;
            we_q   <= 1'b0;
            uns_q  <= 1'b0;
            size_q <= SZ_BYTE;
            adr_q  <= '0;
            wd_q   <= '0;
            rd_q   <= '0;
            err_q  <= 1'b0;
        end else begin
            if (state == IDLE && bus.req) begin
                we_q   <= bus.we;
                uns_q  <= bus.uns;
                size_q <= bus.size;
                adr_q  <= bus.adr;
                wd_q   <= bus.wd;
                cnt    <= CNT_LOAD;
            end else if (state == WAIT && cnt != '0) begin
                cnt <= cnt - CW'(1);
            end
            if (do_access) begin
                err_q <= bad;
                rd_q  <= (bad || we_q) ? '0 : lval;
            end
        end
    end

    assign bus.rd  = rd_q;
    assign bus.err = err_q;

    // ---------------- alignment / range check ----------------
    always_comb begin
        bad = 1'b0;
        case (size_q)
            SZ_HALF: bad = adr_q[0];
            SZ_WORD: bad = |adr_q[1:0];
            SZ_BAD:  bad = 1'b1;
            default: bad = 1'b0;
        endcase
        if ({2'b00, adr_q[31:2]} >= WORDS) bad = 1'b1;
    end

    // ---------------- store lane steering ----------------
    // Replicating the data across lanes lets the byte enables pick the lane.
    always_comb begin
        be    = 4'b0000;
        wlane = wd_q;
        case (size_q)
            SZ_BYTE: begin
                be    = 4'b0001 << adr_q[1:0];
                wlane = {4{wd_q[7:0]}};
            end
            SZ_HALF: begin
                be    = adr_q[1] ? 4'b1100 : 4'b0011;
                wlane = {2{wd_q[15:0]}};
            end
            SZ_WORD: begin
                be    = 4'b1111;
                wlane = wd_q;
            end
            default: be = 4'b0000;
        endcase
    end

    // Write only on the access edge of a legal store; an abandoned access
    // never reaches this edge because reset forces IDLE asynchronously.
    assign ram_be = (do_access && we_q && !bad) ? be : 4'b0000;

    dmem_ram #(
        .WORDS (WORDS),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .be    (ram_be),
        .addr  (adr_q[AW+1:2]),
        .wdata (wlane),
        .rdata (rword)
    );

    // ---------------- load extraction / extension ----------------
    assign shifted = rword >> {adr_q[1:0], 3'b000};

    always_comb begin
        lval = rword;
        case (size_q)
            SZ_BYTE: lval = uns_q ? {24'h0, shifted[7:0]}
                                  : {{24{shifted[7]}}, shifted[7:0]};
            SZ_HALF: lval = uns_q ? {16'h0, shifted[15:0]}
                                  : {{16{shifted[15]}}, shifted[15:0]};
            default: lval = rword;
        endcase
    end

endmodule
